// File: rtl/regfile_operand_fetch.sv
// Operand fetch front end of the register file: holds one instruction, checks it
// against an in-flight destination scoreboard, and registers the resolved operand bundle.
module regfile_operand_fetch #(
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              CK_REF,
    input  logic              RST_N,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [31:0]       INSTR_IN,
    input  logic              WB_VALID,
    input  logic [4:0]        WB_RD,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic              REG_RD_WRN,
    output logic [4:0]        RS1_REG_OFFSET,
    output logic [4:0]        RS2_REG_OFFSET,
    output logic [4:0]        RD_REG_OFFSET,
    output logic [DATA_W-1:0] REG_DATA_IN,
    input  logic [DATA_W-1:0] RS1_DATA_OUT,
    input  logic [DATA_W-1:0] RS2_DATA_OUT,
    output logic              OP_VALID,
    input  logic              OP_READY,
    output logic [31:0]       OP_INSTR,
    output logic [DATA_W-1:0] OP_RS1,
    output logic [DATA_W-1:0] OP_RS2,
    output logic [4:0]        OP_RD
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {EMPTY, HOLD, OUT} state_t;

    state_t      state;
    logic [31:0] held_instr;
    logic [31:0] sb;
    logic [31:0] sb_next;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        stall;
    logic        issue;

    function automatic logic src_busy(input logic use_r, input logic [4:0] r,
                                      input logic [31:0] sbv, input logic wbv,
                                      input logic [4:0] wbr);
        return use_r && (r != 5'd0) && sbv[r] && !(FWD_EN && wbv && (wbr == r));
    endfunction

    function automatic logic [DATA_W-1:0] operand(input logic use_r, input logic [4:0] r,
                                                  input logic [DATA_W-1:0] rf_data,
                                                  input logic wbv, input logic [4:0] wbr,
                                                  input logic [DATA_W-1:0] wbd);
        if (!use_r || (r == 5'd0))
            return '0;
        else if (FWD_EN && wbv && (wbr == r))
            return wbd;
        else
            return rf_data;
    endfunction

    assign opcode = held_instr[6:0];
    assign rs1    = held_instr[19:15];
    assign rs2    = held_instr[24:20];
    assign rd     = held_instr[11:7];

    assign uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign writes_rd = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && (rd != 5'd0);

    // WAW check ignores FWD_EN: a same-cycle writeback of rd always retires the older write.
    assign stall = src_busy(uses_rs1, rs1, sb, WB_VALID, WB_RD)
                 | src_busy(uses_rs2, rs2, sb, WB_VALID, WB_RD)
                 | (writes_rd && sb[rd] && !(WB_VALID && (WB_RD == rd)));
    assign issue = (state == HOLD) && !stall;

    assign REG_RD_WRN     = ~(WB_VALID & RST_N);
    assign RD_REG_OFFSET  = WB_RD;
    assign REG_DATA_IN    = WB_DATA;
    assign RS1_REG_OFFSET = rs1;
    assign RS2_REG_OFFSET = rs2;
    assign INSTR_READY    = (state == EMPTY) || ((state == OUT) && OP_READY);

    // Set is applied after clear so a register issued and retired in one cycle stays busy.
    always_comb begin
        sb_next = sb;
        if (WB_VALID && (WB_RD != 5'd0))
            sb_next[WB_RD] = 1'b0;
        if (issue && writes_rd)
            sb_next[rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state      <= EMPTY;
            held_instr <= '0;
            sb         <= '0;
            OP_VALID   <= 1'b0;
            OP_INSTR   <= '0;
            OP_RS1     <= '0;
            OP_RS2     <= '0;
            OP_RD      <= '0;
        end else begin
            sb <= sb_next;
            case (state)
                EMPTY: begin
                    if (INSTR_VALID) begin
                        held_instr <= INSTR_IN;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        OP_VALID <= 1'b1;
                        OP_INSTR <= held_instr;
                        OP_RS1   <= operand(uses_rs1, rs1, RS1_DATA_OUT, WB_VALID, WB_RD, WB_DATA);
                        OP_RS2   <= operand(uses_rs2, rs2, RS2_DATA_OUT, WB_VALID, WB_RD, WB_DATA);
                        OP_RD    <= writes_rd ? rd : 5'd0;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (OP_READY) begin
                        OP_VALID <= 1'b0;
                        if (INSTR_VALID) begin
                            held_instr <= INSTR_IN;
                            state      <= HOLD;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch: one forwarding and one non-forwarding
// instance share stimulus and a small register-file model.
module tb_regfile_operand_fetch;

    localparam logic [31:0] ADDI5 = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] ADD6  = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] LUI0  = 32'h1234_5037; // lui  x0,0x12345
    localparam logic [31:0] ADDI7 = 32'h0010_0393; // addi x7,x0,1

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        op_ready;
    logic        rf_clr;

    logic        f1_instr_ready, f1_reg_rd_wrn, f1_op_valid;
    logic [4:0]  f1_rs1_off, f1_rs2_off, f1_rd_off, f1_op_rd;
    logic [31:0] f1_reg_data_in, f1_rs1_data, f1_rs2_data, f1_op_instr, f1_op_rs1, f1_op_rs2;
    logic        f0_instr_ready, f0_reg_rd_wrn, f0_op_valid;
    logic [4:0]  f0_rs1_off, f0_rs2_off, f0_rd_off, f0_op_rd;
    logic [31:0] f0_reg_data_in, f0_rs1_data, f0_rs2_data, f0_op_instr, f0_op_rs1, f0_op_rs2;

    logic [31:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (!f1_reg_rd_wrn && (f1_rd_off != 5'd0)) begin
            rf[f1_rd_off] <= f1_reg_data_in;
        end
    end

    assign f1_rs1_data = rf[f1_rs1_off];
    assign f1_rs2_data = rf[f1_rs2_off];
    assign f0_rs1_data = rf[f0_rs1_off];
    assign f0_rs2_data = rf[f0_rs2_off];

    regfile_operand_fetch #(.DATA_W(32), .FWD_EN(1'b1)) dut1 (
        .CK_REF(clk), .RST_N(rst_n),
        .INSTR_VALID(instr_valid), .INSTR_READY(f1_instr_ready), .INSTR_IN(instr_in),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .WB_DATA(wb_data),
        .REG_RD_WRN(f1_reg_rd_wrn), .RS1_REG_OFFSET(f1_rs1_off), .RS2_REG_OFFSET(f1_rs2_off),
        .RD_REG_OFFSET(f1_rd_off), .REG_DATA_IN(f1_reg_data_in),
        .RS1_DATA_OUT(f1_rs1_data), .RS2_DATA_OUT(f1_rs2_data),
        .OP_VALID(f1_op_valid), .OP_READY(op_ready), .OP_INSTR(f1_op_instr),
        .OP_RS1(f1_op_rs1), .OP_RS2(f1_op_rs2), .OP_RD(f1_op_rd)
    );

    regfile_operand_fetch #(.DATA_W(32), .FWD_EN(1'b0)) dut0 (
        .CK_REF(clk), .RST_N(rst_n),
        .INSTR_VALID(instr_valid), .INSTR_READY(f0_instr_ready), .INSTR_IN(instr_in),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .WB_DATA(wb_data),
        .REG_RD_WRN(f0_reg_rd_wrn), .RS1_REG_OFFSET(f0_rs1_off), .RS2_REG_OFFSET(f0_rs2_off),
        .RD_REG_OFFSET(f0_rd_off), .REG_DATA_IN(f0_reg_data_in),
        .RS1_DATA_OUT(f0_rs1_data), .RS2_DATA_OUT(f0_rs2_data),
        .OP_VALID(f0_op_valid), .OP_READY(op_ready), .OP_INSTR(f0_op_instr),
        .OP_RS1(f0_op_rs1), .OP_RS2(f0_op_rs2), .OP_RD(f0_op_rd)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; instr_valid = 1'b0; instr_in = '0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rf_clr = 1'b1;

        // reset with a writeback offered: write port must stay disabled
        #2 rst_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        #1;
        check_val("rst_op_valid", f1_op_valid, 1'b0);
        check_val("rst_op_instr", f1_op_instr, 32'h0);
        check_val("rst_op_rd", f1_op_rd, 5'd0);
        check_val("rst_op_rs1", f1_op_rs1, 32'h0);
        check_val("rst_wrn", f1_reg_rd_wrn, 1'b1);
        check_val("rst_wrn_f0", f0_reg_rd_wrn, 1'b1);
        check_val("rst_instr_ready", f1_instr_ready, 1'b1);
        check_val("rst_sb", dut1.sb, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; wb_valid = 1'b0; rf_clr = 1'b0;

        // ADDI x5,x0,7 with forwarding instance
        instr_valid = 1'b1; instr_in = ADDI5;
        #1 check_val("empty_ready", f1_instr_ready, 1'b1);
        @(negedge clk);
        check_val("hold_op_valid", f1_op_valid, 1'b0);
        check_val("hold_ready", f1_instr_ready, 1'b0);
        check_val("hold_rs1_off", f1_rs1_off, 5'd0);
        instr_valid = 1'b0;
        @(negedge clk);
        check_val("addi_valid", f1_op_valid, 1'b1);
        check_val("addi_instr", f1_op_instr, ADDI5);
        check_val("addi_rs1", f1_op_rs1, 32'h0);
        check_val("addi_rs2", f1_op_rs2, 32'h0);
        check_val("addi_rd", f1_op_rd, 5'd5);
        check_val("addi_sb5", dut1.sb[5], 1'b1);
        check_val("out_ready_low", f1_instr_ready, 1'b0);

        // ADD x6,x5,x5 accepted in the same edge that retires the bundle
        op_ready = 1'b1; instr_valid = 1'b1; instr_in = ADD6;
        #1 check_val("out_ready_pass", f1_instr_ready, 1'b1);
        @(negedge clk);
        check_val("add_hold_valid", f1_op_valid, 1'b0);
        check_val("add_rs1_off", f1_rs1_off, 5'd5);
        check_val("add_rs2_off", f1_rs2_off, 5'd5);
        instr_valid = 1'b0; op_ready = 1'b0;
        @(negedge clk);
        check_val("add_stall", f1_op_valid, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
        #1;
        check_val("wb_wrn", f1_reg_rd_wrn, 1'b0);
        check_val("wb_rd_off", f1_rd_off, 5'd5);
        check_val("wb_data_in", f1_reg_data_in, 32'h7);
        @(negedge clk);
        wb_valid = 1'b0;
        check_val("fwd_valid", f1_op_valid, 1'b1);
        check_val("fwd_rs1", f1_op_rs1, 32'h7);
        check_val("fwd_rs2", f1_op_rs2, 32'h7);
        check_val("fwd_rd", f1_op_rd, 5'd6);
        check_val("fwd_sb", dut1.sb, 32'h0000_0040);

        // x0 writeback while draining: write issued, scoreboard untouched
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD; op_ready = 1'b1;
        #1 check_val("x0_wrn", f1_reg_rd_wrn, 1'b0);
        @(negedge clk);
        wb_valid = 1'b0; op_ready = 1'b0;
        check_val("drain_valid", f1_op_valid, 1'b0);
        check_val("drain_ready", f1_instr_ready, 1'b1);
        check_val("x0_sb", dut1.sb, 32'h0000_0040);

        // LUI x0 sets nothing and does not stall
        instr_valid = 1'b1; instr_in = LUI0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_val("lui_valid", f1_op_valid, 1'b1);
        check_val("lui_rd", f1_op_rd, 5'd0);
        check_val("lui_rs1", f1_op_rs1, 32'h0);
        check_val("lui_sb", dut1.sb, 32'h0000_0040);

        // back-pressure for 5 cycles with a new instruction offered
        instr_valid = 1'b1; instr_in = ADDI7;
        for (int i = 0; i < 5; i++) begin
            #1 check_val("bp_ready", f1_instr_ready, 1'b0);
            @(negedge clk);
            check_val("bp_valid", f1_op_valid, 1'b1);
            check_val("bp_instr", f1_op_instr, LUI0);
        end
        op_ready = 1'b1;
        #1 check_val("bp_release_ready", f1_instr_ready, 1'b1);
        @(negedge clk);
        op_ready = 1'b0; instr_valid = 1'b0;
        check_val("bp_hold_valid", f1_op_valid, 1'b0);
        @(negedge clk);
        check_val("addi7_valid", f1_op_valid, 1'b1);
        check_val("addi7_rd", f1_op_rd, 5'd7);
        check_val("addi7_sb", dut1.sb, 32'h0000_00C0);

        // asynchronous reset while stalled in HOLD with sb[5] pending
        op_ready = 1'b1; instr_valid = 1'b1; instr_in = ADDI5;
        @(negedge clk);
        op_ready = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_sb5", dut1.sb[5], 1'b1);
        op_ready = 1'b1; instr_valid = 1'b1; instr_in = ADD6;
        @(negedge clk);
        op_ready = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_stall", f1_op_valid, 1'b0);
        #2 rst_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9;
        #1;
        check_val("arst_valid", f1_op_valid, 1'b0);
        check_val("arst_wrn", f1_reg_rd_wrn, 1'b1);
        check_val("arst_sb", dut1.sb, 32'h0);
        check_val("arst_instr", f1_op_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; wb_valid = 1'b0;
        #1 check_val("arst_release_ready", f1_instr_ready, 1'b1);

        // non-forwarding instance: same hazard costs one extra cycle
        @(negedge clk);
        rst_n = 1'b0; rf_clr = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; rf_clr = 1'b0;
        instr_valid = 1'b1; instr_in = ADDI5;
        #1 check_val("nf_ready", f0_instr_ready, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_val("nf_addi_valid", f0_op_valid, 1'b1);
        check_val("nf_addi_rd", f0_op_rd, 5'd5);
        op_ready = 1'b1; instr_valid = 1'b1; instr_in = ADD6;
        @(negedge clk);
        instr_valid = 1'b0; op_ready = 1'b0;
        @(negedge clk);
        check_val("nf_stall1", f0_op_valid, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
        #1;
        check_val("nf_wrn", f0_reg_rd_wrn, 1'b0);
        check_val("nf_rd_off", f0_rd_off, 5'd5);
        check_val("nf_data_in", f0_reg_data_in, 32'h7);
        @(negedge clk);
        wb_valid = 1'b0;
        check_val("nf_stall2", f0_op_valid, 1'b0);
        check_val("nf_sb5_clear", dut0.sb[5], 1'b0);
        @(negedge clk);
        check_val("nf_valid", f0_op_valid, 1'b1);
        check_val("nf_instr", f0_op_instr, ADD6);
        check_val("nf_rs1", f0_op_rs1, 32'h7);
        check_val("nf_rs2", f0_op_rs2, 32'h7);
        check_val("nf_rd", f0_op_rd, 5'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Client side of the register file: accepts 32-bit RV32I instructions over a valid/ready handshake and drives the RS1/RS2 read offsets.
- Captures the operands into an output register.
- Owns the register-file write port, driven from the writeback interface.
- Tracks in-flight destination registers in a 32-bit scoreboard, stalls on RAW/WAW hazards, and forwards same-cycle writeback data.

Parameters:
- DATA_W, 32, operand/writeback data width.
- FWD_EN, 1, 1 forwards same-cycle WB data to operand capture; 0 stalls one cycle instead.

Ports:
- CK_REF  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- INSTR_VALID  in  1  instruction offered.
- INSTR_READY  out  1  instruction accepted when VALID&READY.
- INSTR_IN  in  32  instruction word.
- WB_VALID  in  1  writeback request; always accepted.
- WB_RD  in  5  writeback destination.
- WB_DATA  in  DATA_W  writeback value.
- REG_RD_WRN  out  1  to register file; low = write this edge.
- RS1_REG_OFFSET  out  5  to register file.
- RS2_REG_OFFSET  out  5  to register file.
- RD_REG_OFFSET  out  5  to register file.
- REG_DATA_IN  out  DATA_W  to register file.
- RS1_DATA_OUT  in  DATA_W  combinational read data from register file.
- RS2_DATA_OUT  in  DATA_W  combinational read data from register file.
- OP_VALID  out  1  operand bundle valid.
- OP_READY  in  1  downstream accepts bundle.
- OP_INSTR  out  32  instruction of bundle.
- OP_RS1  out  DATA_W  rs1 operand.
- OP_RS2  out  DATA_W  rs2 operand.
- OP_RD  out  5  destination (0 if instruction writes no rd).

Behaviour:
- Reset: state EMPTY, scoreboard 0, held instr 0, OP_VALID 0, OP_INSTR/OP_RS1/OP_RS2/OP_RD 0. REG_RD_WRN high while RST_N low. Reset mid-operation discards the held instruction and all pending bits.
- Write port, combinational pass-through:
  - REG_RD_WRN = ~WB_VALID.
  - RD_REG_OFFSET = WB_RD.
  - REG_DATA_IN = WB_DATA.
- Read offsets: RS1_REG_OFFSET = held_instr[19:15], RS2_REG_OFFSET = held_instr[24:20].
- Decode of opcode [6:0]:
  - uses_rs1 false for LUI (0110111), AUIPC (0010111), JAL (1101111); otherwise true.
  - uses_rs2 true only for OP (0110011), STORE (0100011), BRANCH (1100011).
  - writes_rd false for STORE and BRANCH, and whenever rd==0.
- Hazard, evaluated in HOLD:
  - src_busy(r) = uses & r!=0 & sb[r] & !(FWD_EN & WB_VALID & WB_RD==r).
  - stall = src_busy(rs1) | src_busy(rs2) | (writes_rd & sb[rd] & !(WB_VALID & WB_RD==rd)).
- State EMPTY: INSTR_READY=1. On handshake, latch INSTR_IN, go to HOLD.
- State HOLD: INSTR_READY=0.
  - If !stall, register the operand bundle, set OP_VALID, go to OUT.
  - Operand = 0 for r==0 or unused; else WB_DATA if FWD_EN & WB_VALID & WB_RD==r; else RSx_DATA_OUT.
- State OUT: OP_VALID=1 and bundle held stable until OP_READY.
  - INSTR_READY = OP_READY.
  - OP_READY & INSTR_VALID: latch the new instruction, go to HOLD.
  - OP_READY & !INSTR_VALID: go to EMPTY.
  - OP_VALID deasserts on the edge where OP_READY is sampled, unless HOLD→OUT follows.
- Scoreboard:
  - On HOLD→OUT with writes_rd, set sb[rd].
  - On WB_VALID with WB_RD!=0, clear sb[WB_RD].
  - Same register set and cleared in the same cycle: set wins.
  - sb[0] is constant 0.
- Latency: accept at edge N, HOLD during N+1, OP_VALID at N+2 if no stall. Peak throughput is 1 instruction per 2 cycles.
- WB_VALID with WB_RD==0 drives a write of x0; the register file discards it. The scoreboard is unchanged.

Test Plan:
- Reset, then ADDI x5,x0,7 (0x00700293) → OP_VALID 2 cycles after accept; OP_RS1=0, OP_RD=5; sb[5]=1.
- Then ADD x6,x5,x5 with no WB → stays in HOLD, OP_VALID=0. WB_VALID, WB_RD=5, WB_DATA=0x7 → next cycle OP_RS1=OP_RS2=0x7 (forwarded); sb[5] clears while sb[6] is set.
- FWD_EN=0, same sequence → one extra stall cycle; operands 0x7 are read back from the register file.
- LUI x0,0x12345 → OP_RD=0, no scoreboard bit set, no stall on any following instruction.
- OP_READY held low for 5 cycles in OUT → bundle and OP_VALID stable, INSTR_READY=0. OP_READY=1 with INSTR_VALID=1 → accept and OUT→HOLD in the same edge.
- Assert RST_N low mid-HOLD with sb[5]=1 → OP_VALID=0, REG_RD_WRN=1, scoreboard cleared immediately (asynchronous). After release, INSTR_READY=1.
